// File: rtl/inport_conditioner.sv
// ----------------------------------------------------------------------------
// inport_conditioner
//   Conditions the raw board switches and the Stop push-button before they
//   reach the CPU datapath. Every raw input is brought into the Clock domain
//   through a flip-flop synchroniser. The switch word is then debounced as a
//   single unit, so only whole, settled words ever appear on inport_data. The
//   Stop level is debounced by an independent channel with the same rules.
//
// Ports
//   Clock          in   1      system clock, rising edge
//   Reset          in   1      asynchronous, active-high reset
//   sw_raw         in   WIDTH  raw switch levels (asynchronous, may bounce)
//   btn_stop_raw   in   1      raw Stop button level (asynchronous, may bounce)
//   inport_data    out  WIDTH  debounced switch word, registered
//   inport_changed out  1      1-cycle pulse when inport_data takes a new value
//   busy           out  1      high while the word channel is settling
//   stop_out       out  1      debounced Stop level, registered
//   stop_press     out  1      1-cycle pulse on a debounced 0->1 of stop_out
// ----------------------------------------------------------------------------
module inport_conditioner #(
    parameter int WIDTH        = 32,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CNT = 50000,
    parameter int CNT_W        = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             btn_stop_raw,
    output logic [WIDTH-1:0] inport_data,
    output logic             inport_changed,
    output logic             busy,
    output logic             stop_out,
    output logic             stop_press
);

    // Reject configurations the counter or synchroniser cannot support.
    if (DEBOUNCE_CNT < 1) begin : g_bad_debounce
        $error("inport_conditioner: DEBOUNCE_CNT must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("inport_conditioner: SYNC_STAGES must be at least 2");
    end
    if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CNT)) begin : g_bad_cnt_w
        $error("inport_conditioner: CNT_W too narrow for DEBOUNCE_CNT-1");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    // Synchroniser chains; index 0 is the stage fed by the raw pin.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sw_sync;
    logic [SYNC_STAGES-1:0]            r_stop_sync;
    logic [WIDTH-1:0]                  w_sw_s;
    logic                              w_stop_s;

    // Word channel
    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load_cand;
    logic             w_cnt_inc;
    logic             w_commit;

    // Stop channel
    logic             r_stop_settle;
    logic             r_stop_cand;
    logic [CNT_W-1:0] r_stop_cnt;

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_sw_sync   <= '0;
            r_stop_sync <= '0;
        end else begin
            r_sw_sync   <= {r_sw_sync[SYNC_STAGES-2:0], sw_raw};
            r_stop_sync <= {r_stop_sync[SYNC_STAGES-2:0], btn_stop_raw};
        end
    end

    assign w_sw_s   = r_sw_sync[SYNC_STAGES-1];
    assign w_stop_s = r_stop_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Word FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_STABLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Word FSM: next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load_cand  = 1'b0;
        w_cnt_inc    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (w_sw_s != inport_data) begin
                    w_load_cand  = 1'b1;
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_sw_s != r_cand) begin
                    // Input moved again: restart the stability window.
                    w_load_cand = 1'b1;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_next = ST_STABLE;
                    // A word that bounced back to the committed value
                    // finishes silently.
                    w_commit     = (r_cand != inport_data);
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: w_state_next = ST_STABLE;
        endcase
    end

    assign busy = (r_state == ST_SETTLE);

    // ------------------------------------------------------------------
    // Word datapath: candidate, counter, committed word
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_cand         <= '0;
            r_cnt          <= '0;
            inport_data    <= '0;
            inport_changed <= 1'b0;
        end else begin
            inport_changed <= w_commit;
            if (w_load_cand) begin
                r_cand <= w_sw_s;
                r_cnt  <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_commit) begin
                inport_data <= r_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stop channel: same restart/commit rules as the word, one bit wide
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_stop_settle <= 1'b0;
            r_stop_cand   <= 1'b0;
            r_stop_cnt    <= '0;
            stop_out      <= 1'b0;
            stop_press    <= 1'b0;
        end else begin
            stop_press <= 1'b0;
            if (!r_stop_settle) begin
                if (w_stop_s != stop_out) begin
                    r_stop_cand   <= w_stop_s;
                    r_stop_cnt    <= '0;
                    r_stop_settle <= 1'b1;
                end
            end else if (w_stop_s != r_stop_cand) begin
                r_stop_cand <= w_stop_s;
                r_stop_cnt  <= '0;
            end else if (r_stop_cnt == CNT_MAX) begin
                r_stop_settle <= 1'b0;
                if (r_stop_cand != stop_out) begin
                    stop_out   <= r_stop_cand;
                    // Pulse only on the press, never on the release.
                    stop_press <= r_stop_cand;
                end
            end else begin
                r_stop_cnt <= r_stop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inport_conditioner.sv
// ----------------------------------------------------------------------------
// tb_inport_conditioner
//   Directed bench for inport_conditioner with DEBOUNCE_CNT=4, SYNC_STAGES=2.
//   A clean step is expected to commit on the 7th rising edge after the
//   change (2 synchroniser edges + 1 to enter SETTLE + 4 counting edges).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inport_conditioner;

    localparam int WIDTH = 32;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic [WIDTH-1:0] sw_raw = '0;
    logic             btn_stop_raw = 1'b0;
    logic [WIDTH-1:0] inport_data;
    logic             inport_changed;
    logic             busy;
    logic             stop_out;
    logic             stop_press;

    int checks   = 0;
    int failures = 0;

    inport_conditioner #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2),
        .DEBOUNCE_CNT(4),
        .CNT_W       (16)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .sw_raw        (sw_raw),
        .btn_stop_raw  (btn_stop_raw),
        .inport_data   (inport_data),
        .inport_changed(inport_changed),
        .busy          (busy),
        .stop_out      (stop_out),
        .stop_press    (stop_press)
    );

    always #5 Clock = ~Clock;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        sw_raw       = '0;
        btn_stop_raw = 1'b0;
        Reset        = 1'b1;
        tick();
        Reset        = 1'b0;
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] exp_d;
        // Reset state
        Reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({inport_data, inport_changed, busy, stop_out, stop_press} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h/%b/%b/%b/%b exp=0", inport_data,
                     inport_changed, busy, stop_out, stop_press);
        end
        Reset = 1'b0;
        tick();
        // Start a settle, then abort it with an asynchronous reset.
        sw_raw = 32'hA5;
        repeat (4) tick();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_busy got=%b exp=1", busy);
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({inport_data, inport_changed, busy, stop_out, stop_press} !== '0) begin
            failures++;
            $display("FAIL reset_async got=%h/%b/%b/%b/%b exp=0", inport_data,
                     inport_changed, busy, stop_out, stop_press);
        end
        tick();
        #2 Reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_d = (e >= 7) ? 32'hA5 : 32'h0;
            checks++;
            if (inport_data !== exp_d) begin
                failures++;
                $display("FAIL reset_rel_data e=%0d got=%h exp=%h", e, inport_data, exp_d);
            end
            checks++;
            if (inport_changed !== (e == 7)) begin
                failures++;
                $display("FAIL reset_rel_pulse e=%0d got=%b exp=%b", e, inport_changed, (e == 7));
            end
        end
    endtask

    task automatic test_step();
        logic [WIDTH-1:0] exp_d;
        do_reset();
        sw_raw = 32'h0000_00FF;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_d = (e >= 7) ? 32'h0000_00FF : 32'h0;
            checks++;
            if (inport_data !== exp_d) begin
                failures++;
                $display("FAIL step_data e=%0d got=%h exp=%h", e, inport_data, exp_d);
            end
            checks++;
            if (inport_changed !== (e == 7)) begin
                failures++;
                $display("FAIL step_pulse e=%0d got=%b exp=%b", e, inport_changed, (e == 7));
            end
            checks++;
            if (busy !== (e >= 3 && e <= 6)) begin
                failures++;
                $display("FAIL step_busy e=%0d got=%b exp=%b", e, busy, (e >= 3 && e <= 6));
            end
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        logic [WIDTH-1:0] exp_d;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            sw_raw = (k % 2 == 0) ? 32'h1 : 32'h0;
            repeat (2) begin
                tick();
                if (inport_changed) pulses++;
            end
        end
        checks++;
        if (pulses != 0 || inport_data !== 32'h0) begin
            failures++;
            $display("FAIL bounce_toggle pulses=%0d data=%h exp=0/0", pulses, inport_data);
        end
        sw_raw = 32'h1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp_d = (e >= 7) ? 32'h1 : 32'h0;
            checks++;
            if (inport_data !== exp_d) begin
                failures++;
                $display("FAIL bounce_data e=%0d got=%h exp=%h", e, inport_data, exp_d);
            end
            checks++;
            if (inport_changed !== (e == 7)) begin
                failures++;
                $display("FAIL bounce_pulse e=%0d got=%b exp=%b", e, inport_changed, (e == 7));
            end
        end
    endtask

    task automatic test_glitch();
        int   pulses   = 0;
        logic saw_busy = 1'b0;
        do_reset();
        sw_raw = 32'h3;
        repeat (8) tick();
        checks++;
        if (inport_data !== 32'h3) begin
            failures++;
            $display("FAIL glitch_setup got=%h exp=%h", inport_data, 32'h3);
        end
        sw_raw = 32'h7;
        tick();
        sw_raw = 32'h3;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (busy) saw_busy = 1'b1;
            if (inport_changed) pulses++;
            checks++;
            if (inport_data !== 32'h3) begin
                failures++;
                $display("FAIL glitch_data e=%0d got=%h exp=%h", e, inport_data, 32'h3);
            end
        end
        checks++;
        if (saw_busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_settle got=%b exp=1", saw_busy);
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL glitch_pulse got=%0d exp=0", pulses);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_stable got=%b exp=0", busy);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        sw_raw       = 32'h1;
        btn_stop_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (stop_out !== (e >= 7)) begin
                failures++;
                $display("FAIL sim_stop e=%0d got=%b exp=%b", e, stop_out, (e >= 7));
            end
            checks++;
            if (stop_press !== (e == 7)) begin
                failures++;
                $display("FAIL sim_press e=%0d got=%b exp=%b", e, stop_press, (e == 7));
            end
            checks++;
            if (inport_data !== ((e >= 7) ? 32'h1 : 32'h0)) begin
                failures++;
                $display("FAIL sim_data e=%0d got=%h exp=%h", e, inport_data,
                         ((e >= 7) ? 32'h1 : 32'h0));
            end
            checks++;
            if (inport_changed !== (e == 7)) begin
                failures++;
                $display("FAIL sim_pulse e=%0d got=%b exp=%b", e, inport_changed, (e == 7));
            end
        end
    endtask

    task automatic test_stop_release();
        // Continues from test_simultaneous: stop_out=1, inport_data=1.
        btn_stop_raw = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (stop_out !== (e < 7)) begin
                failures++;
                $display("FAIL rel_stop e=%0d got=%b exp=%b", e, stop_out, (e < 7));
            end
            checks++;
            if (stop_press !== 1'b0) begin
                failures++;
                $display("FAIL rel_press e=%0d got=%b exp=0", e, stop_press);
            end
            checks++;
            if (inport_data !== 32'h1 || inport_changed !== 1'b0) begin
                failures++;
                $display("FAIL rel_word e=%0d got=%h/%b exp=1/0", e, inport_data, inport_changed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_stop_release();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
